// File: rtl/morse_char_sequencer.sv
// Morse keying sequencer: times key marks/spaces against a unit tick, builds the
// symbol vector for an external recognizer and hands characters out via valid/ready.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no character in progress, waiting for a key press
// MARK      | key held, counting ticks to classify dit/dah
// GAP       | key released, waiting for a character gap
// EMIT      | character latched, waiting for downstream acceptance
// WGAP      | between characters, waiting for a word gap
// EMIT_WORD | space latched, waiting for downstream acceptance
module morse_char_sequencer #(
    parameter int MORSE_LEN_W    = 3,
    parameter int MAX_MORSE_LEN  = 5,
    parameter int CHAR_W         = 8,
    parameter int CNT_W          = 8,
    parameter int DAH_UNITS      = 3,
    parameter int CHAR_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     key,
    input  logic                     tick,
    output logic [MORSE_LEN_W-1:0]   rec_len,
    output logic [MAX_MORSE_LEN-1:0] rec_dits_dahs,
    input  logic [CHAR_W-1:0]        rec_char,
    output logic [CHAR_W-1:0]        out_char,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err_overflow,
    output logic                     err_overrun
);

    typedef enum logic [2:0] {
        IDLE, MARK, GAP, EMIT, WGAP, EMIT_WORD
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic [MORSE_LEN_W-1:0]   len_q, len_d;
    logic [MAX_MORSE_LEN-1:0] vec_q, vec_d;
    logic [CHAR_W-1:0]        out_char_q, out_char_d;
    logic                     out_valid_q, out_valid_d;
    logic                     err_overflow_q, err_overflow_d;
    logic                     err_overrun_q, err_overrun_d;
    logic                     key_q, key_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            len_q          <= '0;
            vec_q          <= '0;
            out_char_q     <= '0;
            out_valid_q    <= 1'b0;
            err_overflow_q <= 1'b0;
            err_overrun_q  <= 1'b0;
            key_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            len_q          <= len_d;
            vec_q          <= vec_d;
            out_char_q     <= out_char_d;
            out_valid_q    <= out_valid_d;
            err_overflow_q <= err_overflow_d;
            err_overrun_q  <= err_overrun_d;
            key_q          <= key_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        len_d          = len_q;
        vec_d          = vec_q;
        out_char_d     = out_char_q;
        out_valid_d    = out_valid_q;
        err_overflow_d = 1'b0;
        err_overrun_d  = 1'b0;
        key_d          = key;

        if (tick && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                len_d = '0;
                vec_d = '0;
                if (key) begin
                    state_d = MARK;
                    cnt_d   = '0;
                end
            end
            MARK: begin
                if (!key) begin
                    if (len_q == MORSE_LEN_W'(MAX_MORSE_LEN)) begin
                        ovf_d = 1'b1;
                    end else begin
                        vec_d = {vec_q[MAX_MORSE_LEN-2:0], (cnt_q >= CNT_W'(DAH_UNITS))};
                        len_d = len_q + MORSE_LEN_W'(1);
                    end
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                // A press on the threshold cycle continues the character.
                if (key) begin
                    state_d = MARK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(CHAR_GAP_UNITS)) begin
                    if (ovf_q) begin
                        err_overflow_d = 1'b1;
                        ovf_d          = 1'b0;
                        len_d          = '0;
                        vec_d          = '0;
                        state_d        = WGAP;
                    end else begin
                        out_char_d  = rec_char;
                        out_valid_d = 1'b1;
                        state_d     = EMIT;
                    end
                end
            end
            EMIT, EMIT_WORD: begin
                len_d = '0;
                vec_d = '0;
                if (key && !key_q)
                    err_overrun_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = (state_q == EMIT) ? WGAP : IDLE;
                end
            end
            WGAP: begin
                len_d = '0;
                vec_d = '0;
                if (key) begin
                    state_d = MARK;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(WORD_GAP_UNITS)) begin
                    // len is zero here, so the recognizer presents a space.
                    out_char_d  = rec_char;
                    out_valid_d = 1'b1;
                    state_d     = EMIT_WORD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rec_len       = len_q;
    assign rec_dits_dahs = vec_q;
    assign out_char      = out_char_q;
    assign out_valid     = out_valid_q;
    assign err_overflow  = err_overflow_q;
    assign err_overrun   = err_overrun_q;

endmodule
